// File: rtl/mips_fetch_pkg.sv
// rtl/mips_fetch_pkg.sv - shared types and constants for the mips fetch stage
//
// Purpose: state encoding, FIFO entry layout and PC helpers shared by
//          fetch_unit and fetch_fifo.
package mips_fetch_pkg;

   localparam int          INSTR_W = 32;
   localparam logic [31:0] PC_STEP = 32'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [31:0]        pc;
   } fetch_entry_t;

   // Redirect targets are forced onto a word boundary.
   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return pc & ~32'd3;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO holding {instr, pc} entries
//
// Purpose: DEPTH-entry synchronous FIFO between instruction memory and core.
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   push, push_data   write one entry
//   pop               retire the head entry
//   flush             empty the FIFO; dominates push and pop
//   count             current occupancy (0..DEPTH)
//   empty             occupancy is zero
//   head              oldest entry, valid when empty=0
module fetch_fifo
   import mips_fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  fetch_entry_t             push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output fetch_entry_t             head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t   mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic           do_push;
   logic           do_pop;

   // Guards keep the pointers coherent even if a caller misbehaves.
   assign do_push = push & (count != CW'(DEPTH));
   assign do_pop  = pop & ~empty;

   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage feeding the single-cycle mips core
//
// Purpose: issues word fetches over a req/ack handshake, buffers the returned
//          words in a prefetch FIFO and presents {instr, pc} to the core.
//          Redirects flush the FIFO and discard any in-flight response.
// Ports:
//   clock, reset                       clock, asynchronous active-low reset
//   imem_req, imem_addr                fetch request and its (held) address
//   imem_ack, imem_rdata               memory response
//   redirect, redirect_pc              control-flow change from the core
//   instr_valid, instr, instr_pc       FIFO head towards the core
//   instr_ready                        core consumes the head
module fetch_unit
   import mips_fetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t  state;
   logic [31:0]   fetch_pc;
   logic [31:0]   pending_pc;
   logic [31:0]   target_pc;
   logic [CW-1:0] fifo_count;
   logic [CW-1:0] count_next;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   logic          credit;
   fetch_entry_t  push_entry;
   fetch_entry_t  head;

   assign target_pc  = align_pc(redirect_pc);

   // Only a kept response (REQ, no redirect) enters the FIFO.
   assign push       = (state == REQ) & imem_ack & ~redirect;
   assign pop        = ~fifo_empty & instr_ready & ~redirect;
   assign push_entry = '{instr: imem_rdata, pc: fetch_pc};

   // Occupancy after this edge; a redirect empties the FIFO.
   assign count_next = redirect ? '0 : (fifo_count + CW'(push) - CW'(pop));
   assign credit     = (count_next < CW'(DEPTH));

   assign imem_req    = (state != IDLE);
   assign imem_addr   = fetch_pc;
   assign instr_valid = ~fifo_empty;
   assign instr       = head.instr;
   assign instr_pc    = head.pc;

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (redirect),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .head      (head)
   );

   // fetch_pc always names the address on the bus; while a request that
   // must be dropped is outstanding, the redirect target waits in pending_pc.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         fetch_pc   <= RESET_PC;
         pending_pc <= RESET_PC;
      end else if (redirect) begin
         if (state == IDLE || imem_ack) begin
            fetch_pc <= target_pc;
            state    <= REQ;
         end else begin
            pending_pc <= target_pc;
            state      <= DROP;
         end
      end else begin
         case (state)
            IDLE: begin
               if (credit) begin
                  state <= REQ;
               end
            end
            REQ: begin
               if (imem_ack) begin
                  fetch_pc <= fetch_pc + PC_STEP;
                  state    <= credit ? REQ : IDLE;
               end
            end
            DROP: begin
               if (imem_ack) begin
                  fetch_pc <= pending_pc;
                  state    <= REQ;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard testbench for fetch_unit
module tb_fetch_unit;
   import mips_fetch_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready = 1'b0;

   int total = 0;
   int bad = 0;

   always #5 clock = ~clock;

   fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clock       (clock),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_ready (instr_ready)
   );

   task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

   // Memory contents: an arbitrary fixed function of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   // ---------------- memory model ----------------
   int mem_wait_cfg = 0;   // wait cycles per request; negative = random 0..3
   int wait_cnt = 0;

   function automatic int next_lat();
      if (mem_wait_cfg < 0) return int'($urandom_range(0, 3));
      return mem_wait_cfg;
   endfunction

   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (!reset || !imem_req) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            wait_cnt   = next_lat();
         end else if (wait_cnt == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
            wait_cnt   = next_lat();
         end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            wait_cnt--;
         end
      end
   end

   // ---------------- scoreboard ----------------
   // The core must see an unbroken word-sequential stream starting at the
   // most recent redirect target (or RESET_PC), each carrying mem_word(pc).
   fetch_entry_t exp_q[$];
   bit           sb_en = 1'b0;

   task automatic sb_restart(input logic [31:0] start);
      fetch_entry_t e;
      logic [31:0]  pc;
      pc = start;
      exp_q.delete();
      for (int i = 0; i < 300; i++) begin
         e.pc    = pc;
         e.instr = mem_word(pc);
         exp_q.push_back(e);
         pc = pc + 32'd4;
      end
   endtask

   int           ack_cnt = 0;
   logic [31:0]  last_ack_addr = 32'd0;
   int           deliv_cnt = 0;
   fetch_entry_t mon_e;
   logic         prev_req = 1'b0;
   logic         prev_ack = 1'b0;
   logic [31:0]  prev_addr = 32'd0;

   always @(negedge clock) begin
      if (reset && imem_req && imem_ack) begin
         ack_cnt++;
         last_ack_addr = imem_addr;
      end
      if (reset && sb_en && instr_valid && instr_ready && !redirect) begin
         deliv_cnt++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_underflow: got pc %h want no delivery", instr_pc);
         end else begin
            mon_e = exp_q.pop_front();
            check_word("sb_pc", instr_pc, mon_e.pc);
            check_word("sb_instr", instr, mon_e.instr);
         end
      end
      // An unacknowledged request must stay up with the same address.
      if (reset && prev_req && !prev_ack) begin
         check_bit("hold_req", imem_req, 1'b1);
         check_word("hold_addr", imem_addr, prev_addr);
      end
      prev_req  = imem_req & reset;
      prev_ack  = imem_ack;
      prev_addr = imem_addr;
   end

   // ---------------- stimulus helpers ----------------
   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset(input int wcfg, input logic rdy);
      sb_en        = 1'b0;
      reset        = 1'b0;
      redirect     = 1'b0;
      mem_wait_cfg = wcfg;
      instr_ready  = rdy;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      sb_restart(32'h0000_0000);
      sb_en = 1'b1;
      next_cycle();
   endtask

   task automatic start_redirect(input logic [31:0] target);
      redirect    = 1'b1;
      redirect_pc = target;
      sb_restart(target & ~32'd3);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

   int base;
   bit seen;

   initial begin
      // Reset state
      repeat (2) @(posedge clock);
      @(negedge clock);
      check_bit("rst_req", imem_req, 1'b0);
      check_word("rst_addr", imem_addr, 32'h0);
      check_bit("rst_valid", instr_valid, 1'b0);
      check_word("rst_instr", instr, 32'h0);
      check_word("rst_pc", instr_pc, 32'h0);

      // 1: zero-wait streaming
      do_reset(0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         check_bit("t1_req", imem_req, 1'b1);
         check_word("t1_addr", imem_addr, 32'(4 * i));
         if (i > 0) begin
            check_bit("t1_valid", instr_valid, 1'b1);
            check_word("t1_pc", instr_pc, 32'(4 * (i - 1)));
         end
         next_cycle();
      end

      // 2: credit limit with a stalled core
      do_reset(0, 1'b0);
      base = ack_cnt;
      repeat (8) next_cycle();
      @(negedge clock);
      check_word("t2_acks", 32'(ack_cnt - base), 32'd4);
      check_word("t2_last_ack", last_ack_addr, 32'hC);
      check_bit("t2_req_off", imem_req, 1'b0);
      check_bit("t2_valid", instr_valid, 1'b1);
      check_word("t2_head", instr_pc, 32'h0);
      next_cycle();
      instr_ready = 1'b1;
      next_cycle();
      instr_ready = 1'b0;
      @(negedge clock);
      check_bit("t2_req_again", imem_req, 1'b1);
      check_word("t2_addr_10", imem_addr, 32'h10);
      repeat (5) next_cycle();
      @(negedge clock);
      check_word("t2_acks2", 32'(ack_cnt - base), 32'd5);
      check_word("t2_last_ack2", last_ack_addr, 32'h10);
      check_bit("t2_req_off2", imem_req, 1'b0);
      check_word("t2_head2", instr_pc, 32'h4);

      // 3: redirect during a slow request
      do_reset(3, 1'b1);
      @(negedge clock);
      check_word("t3_addr_c0", imem_addr, 32'h0);
      next_cycle();
      start_redirect(32'h100);
      @(negedge clock);
      check_word("t3_addr_c1", imem_addr, 32'h0);
      check_bit("t3_noack_c1", imem_ack, 1'b0);
      next_cycle();
      redirect = 1'b0;
      @(negedge clock);
      check_word("t3_addr_c2", imem_addr, 32'h0);
      next_cycle();
      @(negedge clock);
      check_word("t3_addr_c3", imem_addr, 32'h0);
      check_bit("t3_ack_c3", imem_ack, 1'b1);
      next_cycle();
      @(negedge clock);
      check_word("t3_addr_new", imem_addr, 32'h100);
      check_bit("t3_req_new", imem_req, 1'b1);
      check_bit("t3_valid_c4", instr_valid, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         next_cycle();
         @(negedge clock);
         seen = instr_valid;
      end
      check_bit("t3_delivered", seen, 1'b1);
      check_word("t3_first_pc", instr_pc, 32'h100);
      check_word("t3_first_instr", instr, mem_word(32'h100));

      // 4: misaligned redirect coinciding with an ack
      do_reset(0, 1'b1);
      next_cycle();
      next_cycle();
      start_redirect(32'h203);
      @(negedge clock);
      check_word("t4_addr_8", imem_addr, 32'h8);
      check_bit("t4_ack_8", imem_ack, 1'b1);
      next_cycle();
      redirect = 1'b0;
      @(negedge clock);
      check_bit("t4_valid_off", instr_valid, 1'b0);
      check_word("t4_addr_200", imem_addr, 32'h200);
      check_bit("t4_req", imem_req, 1'b1);
      next_cycle();
      @(negedge clock);
      check_bit("t4_valid_on", instr_valid, 1'b1);
      check_word("t4_pc_200", instr_pc, 32'h200);

      // 5: redirect and pop together with two entries buffered
      do_reset(0, 1'b0);
      next_cycle();
      next_cycle();
      start_redirect(32'h340);
      instr_ready = 1'b1;
      @(negedge clock);
      check_bit("t5_valid_pre", instr_valid, 1'b1);
      check_word("t5_count_pre", 32'(dut.fifo_count), 32'd2);
      next_cycle();
      redirect = 1'b0;
      @(negedge clock);
      check_bit("t5_valid_off", instr_valid, 1'b0);
      check_word("t5_count", 32'(dut.fifo_count), 32'd0);
      next_cycle();
      @(negedge clock);
      check_word("t5_pc", instr_pc, 32'h340);

      // 6: PC wrap, then reset mid-request
      next_cycle();
      start_redirect(32'hFFFF_FFFC);
      next_cycle();
      redirect = 1'b0;
      @(negedge clock);
      check_word("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
      check_bit("t6_valid_off", instr_valid, 1'b0);
      next_cycle();
      @(negedge clock);
      check_word("t6_pc_top", instr_pc, 32'hFFFF_FFFC);
      check_word("t6_addr_wrap", imem_addr, 32'h0);
      next_cycle();
      @(negedge clock);
      check_word("t6_pc_wrap", instr_pc, 32'h0);
      check_bit("t6_req_mid", imem_req, 1'b1);
      #2;
      sb_en = 1'b0;
      reset = 1'b0;
      #1;
      check_bit("t6_rst_req", imem_req, 1'b0);
      check_bit("t6_rst_valid", instr_valid, 1'b0);
      check_word("t6_rst_addr", imem_addr, 32'h0);
      check_word("t6_rst_pc", instr_pc, 32'h0);

      // Random traffic: variable latency, back-pressure and redirects
      do_reset(-1, 1'b1);
      base = deliv_cnt;
      for (int i = 0; i < 3000; i++) begin
         next_cycle();
         instr_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 19) == 0) begin
            if ($urandom_range(0, 3) == 0)
               start_redirect(32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
            else
               start_redirect($urandom);
         end else begin
            redirect = 1'b0;
         end
      end
      redirect = 1'b0;
      next_cycle();
      check_bit("rand_progress", (deliv_cnt - base) >= 200, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the single-cycle mips core.
- Generates instruction addresses and talks to instruction memory over a req/ack handshake with variable latency.
- Buffers fetched words in a small prefetch FIFO and hands {instr, pc} to the core through a valid/ready interface.
- Handles control-flow redirects (branch, j, jal, jr) by flushing the buffer and discarding any in-flight response.

Parameters:
- DEPTH, 4, number of prefetch FIFO entries (power of 2, ≥2).
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned).

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; stable while imem_req=1 until ack.
- imem_ack  input  1  memory returns data this cycle; only meaningful while imem_req=1.
- imem_rdata  input  32  instruction word, valid when imem_ack=1.
- redirect  input  1  core requests a fetch-stream change (taken branch/jump/jr).
- redirect_pc  input  32  new fetch address.
- instr_valid  output  1  FIFO head holds a valid instruction.
- instr  output  32  head instruction word.
- instr_pc  output  32  address of head instruction.
- instr_ready  input  1  core consumes the head this cycle when instr_valid=1.

Behaviour:
- Reset (async, reset=0): state IDLE, fetch_pc=RESET_PC, FIFO empty, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- States:
  - IDLE: no request outstanding.
  - REQ: request outstanding; response will be kept.
  - DROP: request outstanding; response will be discarded.
- imem_req=1 exactly when state is REQ or DROP. imem_addr is always the registered fetch_pc.
- Credit: a new request may issue only if count_next < DEPTH. count_next is the FIFO occupancy after this cycle's push and pop.
- IDLE→REQ when credit is available and redirect=0. The first imem_req is asserted in the first cycle after the first clock edge following reset release.
- REQ with ack=0: hold state; fetch_pc and imem_addr unchanged.
- REQ with ack=1:
  - Push {imem_rdata, fetch_pc}; fetch_pc += 4.
  - Go to REQ if credit remains, else IDLE.
  - A zero-wait memory therefore streams 1 instruction per cycle.
- Fetch latency: an ack in cycle N makes instr_valid=1 with that word in cycle N+1.
- Pop occurs when instr_valid & instr_ready. Head outputs are registered/combinational from FIFO storage; no extra latency.
- Redirect (highest priority, any state):
  - FIFO flushed in the same edge, so instr_valid=0 next cycle. Any simultaneous pop is ignored.
  - fetch_pc = {redirect_pc[31:2], 2'b00}; misaligned low bits are forced to 0.
  - From IDLE: go to REQ next cycle with the new address. fetch_pc is updated, but imem_addr shows the new address only once the request issues.
  - From REQ with ack=0: go to DROP. imem_addr stays at the old address until ack, as the protocol requires; the new PC is held in a pending register.
  - From REQ or DROP with ack=1 in the same cycle: discard the data and go to REQ with the new address.
  - From DROP with ack=0: overwrite the pending PC and stay in DROP.
- DROP with ack=1: discard the data, load the pending PC into fetch_pc, and go to REQ. Credit is always available because the FIFO is empty.
- Full FIFO: a push never coincides with full, by construction of the credit rule. A push and pop in the same cycle keeps the count.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- Reset mid-request: all state clears immediately. An ack arriving while reset=0 is ignored. The memory side must tolerate a dropped request.

Decomposition:
- Package mips_fetch_pkg:
  - INSTR_W=32 and PC_STEP=4.
  - State enum {IDLE, REQ, DROP} with 2-bit encoding.
  - Typedef fetch_entry_t = {instr[31:0], pc[31:0]}.
- Sub-module fetch_fifo: a synchronous DEPTH-entry FIFO.
  - Inputs: push, pop, flush.
  - Outputs: count, empty, head.
  - Asynchronous active-low reset.
  - flush dominates push and pop.

Test Plan:
1. Reset release with zero-wait memory (ack whenever req) and instr_ready=1 → imem_addr runs 0x0, 0x4, 0x8…; instr_pc follows one cycle behind; instr_valid stays continuously 1.
2. instr_ready=0 and DEPTH=4 with zero-wait memory → exactly 4 acks (0x0–0xC); then imem_req=0. One pop → a single new request for 0x10.
3. Memory with 3-cycle latency; redirect to 0x100 in the second wait cycle → imem_addr holds 0x0 until ack, and that data never appears. The next request is 0x100, and the first instr_pc after it is 0x100.
4. Redirect to 0x203 in the same cycle as an ack for 0x8 → 0x8 is dropped; the next imem_addr is 0x200; instr_valid=0 for the following cycle.
5. FIFO holding 2 entries, with redirect and pop in the same cycle → count=0 next cycle, and the next delivered instr_pc is the redirect target.
6. Redirect to 0xFFFF_FFFC, stream 2 instructions → instr_pc sequence 0xFFFF_FFFC, 0x0000_0000. Then assert reset=0 mid-request → imem_req and instr_valid drop immediately, and imem_addr shows RESET_PC.
